// File: rtl/vram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arb_pkg
//  Purpose  : Shared types and constants for the VRAM arbiter (CPU access
//             FSM state encoding and wait-counter width).
//  Revision : 1.0  initial release
// ============================================================================
package vram_arb_pkg;

   // Width of the saturating CPU blocked-cycle counter
   localparam int WAIT_CNT_W = 8;

   // CPU access FSM states
   typedef enum logic [1:0] {
      C_IDLE = 2'd0,   // waiting for a CPU request / free cycle
      C_RD   = 2'd1,   // read issued last cycle, RAM data arriving now
      C_ACK  = 2'd2    // completion pulse cycle
   } cpu_state_t;

endpackage : vram_arb_pkg
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Shares a single-port synchronous VRAM between the VDG display
//             fetch (strict priority) and CPU reads/writes (free cycles,
//             req/ack handshake). Tracks CPU starvation.
//  Revision : 1.0  initial release
// ============================================================================
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk_25,
   input  logic              reset_n,
   // VDG fetch side
   input  logic              vdg_req,
   input  logic [ADDR_W-1:0] vdg_addr,
   output logic [DATA_W-1:0] vdg_data,
   // CPU bus side
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_starve,
   // VRAM macro side
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [WAIT_CNT_W-1:0] c_max_wait = WAIT_CNT_W'(MAX_WAIT);
   localparam logic [WAIT_CNT_W-1:0] c_wait_sat = {WAIT_CNT_W{1'b1}};

   cpu_state_t              r_state;
   logic [WAIT_CNT_W-1:0]   r_wait_cnt;
   logic                    r_vdg_tag;
   logic [DATA_W-1:0]       r_vdg_data;
   logic [DATA_W-1:0]       r_cpu_rdata;
   logic                    r_cpu_ack;
   logic                    r_cpu_starve;

   logic                    w_cpu_issue;
   logic                    w_cpu_blocked;
   logic [WAIT_CNT_W-1:0]   w_wait_nxt;

   // CPU may only issue from idle in a cycle the VDG leaves free; this is
   // what guarantees a write can never collide with a display fetch.
   assign w_cpu_issue   = (r_state == C_IDLE) &  cpu_req & ~vdg_req;
   assign w_cpu_blocked = (r_state == C_IDLE) &  cpu_req &  vdg_req;

   // Grant mux: VDG address wins; otherwise the CPU address is presented
   // (a harmless read when no CPU access is being issued).
   always_comb begin
      ram_addr = vdg_req ? vdg_addr : cpu_addr;
      ram_we   = w_cpu_issue & cpu_we;
   end

   assign ram_wdata = cpu_wdata;

   // Next blocked-cycle count: cleared on issue or idle bus, saturating increment when blocked
   always_comb begin
      w_wait_nxt = r_wait_cnt;
      if (!cpu_req || w_cpu_issue) begin
         w_wait_nxt = '0;
      end else if (w_cpu_blocked && (r_wait_cnt != c_wait_sat)) begin
         w_wait_nxt = r_wait_cnt + WAIT_CNT_W'(1);
      end
   end

   // CPU FSM, VDG capture pipeline, wait counter and registered outputs
   always_ff @(posedge clk_25 or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= C_IDLE;
         r_wait_cnt   <= '0;
         r_vdg_tag    <= 1'b0;
         r_vdg_data   <= '0;
         r_cpu_rdata  <= '0;
         r_cpu_ack    <= 1'b0;
         r_cpu_starve <= 1'b0;
      end else begin
         // VDG fetch: tag follows the strobe so the RAM's 1-cycle-late data
         // is captured exactly once per fetch; pipelined for every-cycle strobes.
         r_vdg_tag <= vdg_req;
         if (r_vdg_tag) begin
            r_vdg_data <= ram_rdata;
         end

         // Starve flag tracks the count being loaded, so it drops the cycle after issue
         r_wait_cnt   <= w_wait_nxt;
         r_cpu_starve <= (w_wait_nxt >= c_max_wait);

         r_cpu_ack <= 1'b0;
         case (r_state)
            C_IDLE: begin
               if (w_cpu_issue) begin
                  if (cpu_we) begin
                     r_state   <= C_ACK;
                     r_cpu_ack <= 1'b1;
                  end else begin
                     r_state   <= C_RD;
                  end
               end
            end
            C_RD: begin
               // Data for the read issued last cycle is on ram_rdata now;
               // a VDG fetch issued this cycle lands next cycle, so no swap.
               r_cpu_rdata <= ram_rdata;
               r_cpu_ack   <= 1'b1;
               r_state     <= C_ACK;
            end
            C_ACK: begin
               r_state <= C_IDLE;
            end
            default: begin
               r_state <= C_IDLE;
            end
         endcase
      end
   end

   assign vdg_data   = r_vdg_data;
   assign cpu_rdata  = r_cpu_rdata;
   assign cpu_ack    = r_cpu_ack;
   assign cpu_starve = r_cpu_starve;

endmodule : vram_arbiter
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Self-checking bench for vram_arbiter with a behavioural
//             synchronous VRAM and expected-data queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

   localparam int ADDR_W   = 14;
   localparam int DATA_W   = 8;
   localparam int MAX_WAIT = 16;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk_25 = 1'b0;
   logic              reset_n;
   logic              vdg_req;
   logic [ADDR_W-1:0] vdg_addr;
   logic [DATA_W-1:0] vdg_data;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_starve;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   logic [DATA_W-1:0] mem    [DEPTH];   // VRAM contents (written by the DUT)
   logic [DATA_W-1:0] shadow [DEPTH];   // bench's own view of what VRAM holds

   logic [DATA_W-1:0] q_cpu [$];
   logic [DATA_W-1:0] q_vdg [$];

   int n_pass  = 0;
   int n_total = 0;
   int n_collide = 0;

   vram_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_dut (
      .clk_25     (clk_25),
      .reset_n    (reset_n),
      .vdg_req    (vdg_req),
      .vdg_addr   (vdg_addr),
      .vdg_data   (vdg_data),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .cpu_starve (cpu_starve),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata)
   );

   always #20 clk_25 = ~clk_25;

   // Synchronous single-port VRAM, 1-cycle read latency
   always @(posedge clk_25) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Any write issued alongside a display fetch is a collision
   always @(posedge clk_25) begin
      if (reset_n && ram_we && vdg_req) n_collide <= n_collide + 1;
   end

   function automatic logic [DATA_W-1:0] init_val(input int a);
      if (a == 'h40) return 8'h3C;
      return DATA_W'((a * 7 + 3) & 'hFF);
   endfunction

   task automatic test_reset();
      reset_n  = 1'b0;
      vdg_req  = 1'b0;
      vdg_addr = '0;
      cpu_req  = 1'b0;
      cpu_we   = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      repeat (3) @(negedge clk_25);
      n_total++; if (vdg_data !== 8'h00) $display("FAIL reset_vdg_data got=%h exp=00", vdg_data); else n_pass++;
      n_total++; if (cpu_rdata !== 8'h00) $display("FAIL reset_cpu_rdata got=%h exp=00", cpu_rdata); else n_pass++;
      n_total++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack got=%b exp=0", cpu_ack); else n_pass++;
      n_total++; if (cpu_starve !== 1'b0) $display("FAIL reset_cpu_starve got=%b exp=0", cpu_starve); else n_pass++;
      reset_n = 1'b1;
      @(negedge clk_25);
   endtask

   task automatic test_cpu_write_read();
      // write 0x0123 <= 0xA5
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 8'hA5;
      shadow['h123] = 8'hA5;
      #1;
      n_total++; if (ram_we !== 1'b1) $display("FAIL wr_ram_we got=%b exp=1", ram_we); else n_pass++;
      n_total++; if (ram_addr !== 14'h0123) $display("FAIL wr_ram_addr got=%h exp=0123", ram_addr); else n_pass++;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL wr_ack_t1 got=%b exp=1", cpu_ack); else n_pass++;
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b0) $display("FAIL wr_ack_pulse got=%b exp=0", cpu_ack); else n_pass++;
      // read back 0x0123
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
      q_cpu.push_back(shadow['h123]);
      #1;
      n_total++; if (ram_we !== 1'b0) $display("FAIL rd_ram_we got=%b exp=0", ram_we); else n_pass++;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_t1 got=%b exp=0", cpu_ack); else n_pass++;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL rd_ack_t2 got=%b exp=1", cpu_ack); else n_pass++;
      begin
         logic [DATA_W-1:0] e = q_cpu.pop_front();
         n_total++; if (cpu_rdata !== e) $display("FAIL rd_data got=%h exp=%h", cpu_rdata, e); else n_pass++;
      end
      cpu_req = 1'b0;
      @(negedge clk_25);
   endtask

   task automatic test_vdg_only();
      vdg_req = 1'b1; vdg_addr = 14'h0040;
      q_vdg.push_back(shadow['h40]);
      #1;
      n_total++; if (ram_addr !== 14'h0040) $display("FAIL vdg_ram_addr got=%h exp=0040", ram_addr); else n_pass++;
      @(negedge clk_25);
      vdg_req = 1'b0;
      @(negedge clk_25);
      begin
         logic [DATA_W-1:0] e = q_vdg.pop_front();
         n_total++; if (vdg_data !== e) $display("FAIL vdg_data_t2 got=%h exp=%h", vdg_data, e); else n_pass++;
         repeat (2) @(negedge clk_25);
         n_total++; if (vdg_data !== e) $display("FAIL vdg_data_held got=%h exp=%h", vdg_data, e); else n_pass++;
      end
   endtask

   task automatic test_collision();
      // read vs fetch in the same cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
      vdg_req = 1'b1; vdg_addr = 14'h0041;
      q_vdg.push_back(shadow['h41]);
      q_cpu.push_back(shadow['h123]);
      #1;
      n_total++; if (ram_addr !== 14'h0041) $display("FAIL col_grant_addr got=%h exp=0041", ram_addr); else n_pass++;
      @(negedge clk_25);
      vdg_req = 1'b0;
      #1;
      n_total++; if (ram_addr !== 14'h0123) $display("FAIL col_cpu_addr got=%h exp=0123", ram_addr); else n_pass++;
      @(negedge clk_25);
      begin
         logic [DATA_W-1:0] e = q_vdg.pop_front();
         n_total++; if (vdg_data !== e) $display("FAIL col_vdg_data got=%h exp=%h", vdg_data, e); else n_pass++;
      end
      n_total++; if (cpu_ack !== 1'b0) $display("FAIL col_ack_early got=%b exp=0", cpu_ack); else n_pass++;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL col_ack got=%b exp=1", cpu_ack); else n_pass++;
      begin
         logic [DATA_W-1:0] e = q_cpu.pop_front();
         n_total++; if (cpu_rdata !== e) $display("FAIL col_rdata got=%h exp=%h", cpu_rdata, e); else n_pass++;
      end
      cpu_req = 1'b0;
      @(negedge clk_25);
      // write vs fetch in the same cycle
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'h77;
      vdg_req = 1'b1; vdg_addr = 14'h0040;
      shadow['h200] = 8'h77;
      q_vdg.push_back(shadow['h40]);
      #1;
      n_total++; if (ram_we !== 1'b0) $display("FAIL col_we_blocked got=%b exp=0", ram_we); else n_pass++;
      @(negedge clk_25);
      vdg_req = 1'b0;
      #1;
      n_total++; if (ram_we !== 1'b1) $display("FAIL col_we_issue got=%b exp=1", ram_we); else n_pass++;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL col_wr_ack got=%b exp=1", cpu_ack); else n_pass++;
      begin
         logic [DATA_W-1:0] e = q_vdg.pop_front();
         n_total++; if (vdg_data !== e) $display("FAIL col_vdg_data2 got=%h exp=%h", vdg_data, e); else n_pass++;
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk_25);
      n_total++; if (n_collide !== 0) $display("FAIL col_no_we_with_vdg got=%0d exp=0", n_collide); else n_pass++;
   endtask

   task automatic test_starvation();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0040;
      q_cpu.push_back(shadow['h40]);
      vdg_req = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         vdg_addr = ADDR_W'(k);
         @(negedge clk_25);
         n_total++;
         if (cpu_starve !== (k >= MAX_WAIT))
            $display("FAIL starve_k%0d got=%b exp=%b", k, cpu_starve, (k >= MAX_WAIT));
         else n_pass++;
         n_total++; if (cpu_ack !== 1'b0) $display("FAIL starve_no_ack_k%0d got=%b exp=0", k, cpu_ack); else n_pass++;
      end
      vdg_req = 1'b0;
      @(negedge clk_25);
      n_total++; if (cpu_starve !== 1'b0) $display("FAIL starve_clear got=%b exp=0", cpu_starve); else n_pass++;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL starve_ack got=%b exp=1", cpu_ack); else n_pass++;
      begin
         logic [DATA_W-1:0] e = q_cpu.pop_front();
         n_total++; if (cpu_rdata !== e) $display("FAIL starve_rdata got=%h exp=%h", cpu_rdata, e); else n_pass++;
      end
      cpu_req = 1'b0;
      @(negedge clk_25);
   endtask

   task automatic test_back_to_back();
      // CPU read issues, then VDG fetches every cycle starting in the C_RD cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0200;
      q_cpu.push_back(shadow['h200]);
      @(negedge clk_25);
      vdg_req = 1'b1; vdg_addr = 14'h0040; q_vdg.push_back(shadow['h40]);
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL pipe_ack got=%b exp=1", cpu_ack); else n_pass++;
      begin
         logic [DATA_W-1:0] e = q_cpu.pop_front();
         n_total++; if (cpu_rdata !== e) $display("FAIL pipe_rdata got=%h exp=%h", cpu_rdata, e); else n_pass++;
      end
      cpu_req = 1'b0;
      vdg_addr = 14'h0041; q_vdg.push_back(shadow['h41]);
      @(negedge clk_25);
      vdg_addr = 14'h0123; q_vdg.push_back(shadow['h123]);
      for (int i = 0; i < 3; i++) begin
         logic [DATA_W-1:0] e = q_vdg.pop_front();
         n_total++; if (vdg_data !== e) $display("FAIL pipe_vdg%0d got=%h exp=%h", i, vdg_data, e); else n_pass++;
         if (i == 0) vdg_req = 1'b1; else vdg_req = 1'b0;
         @(negedge clk_25);
      end
   endtask

   task automatic test_reset_mid_read();
      int acks = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
      @(negedge clk_25);           // now in C_RD
      reset_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      n_total++; if (cpu_ack !== 1'b0) $display("FAIL rst_ack got=%b exp=0", cpu_ack); else n_pass++;
      n_total++; if (cpu_rdata !== 8'h00) $display("FAIL rst_rdata got=%h exp=00", cpu_rdata); else n_pass++;
      n_total++; if (vdg_data !== 8'h00) $display("FAIL rst_vdg_data got=%h exp=00", vdg_data); else n_pass++;
      n_total++; if (cpu_starve !== 1'b0) $display("FAIL rst_starve got=%b exp=0", cpu_starve); else n_pass++;
      @(negedge clk_25);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_25);
         if (cpu_ack === 1'b1) acks++;
      end
      n_total++; if (acks !== 0) $display("FAIL rst_dropped_ack got=%0d exp=0", acks); else n_pass++;
      // normal write then read after reset
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0300; cpu_wdata = 8'h99;
      shadow['h300] = 8'h99;
      @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL post_wr_ack got=%b exp=1", cpu_ack); else n_pass++;
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk_25);
      cpu_req = 1'b1; cpu_addr = 14'h0300;
      q_cpu.push_back(shadow['h300]);
      repeat (2) @(negedge clk_25);
      n_total++; if (cpu_ack !== 1'b1) $display("FAIL post_rd_ack got=%b exp=1", cpu_ack); else n_pass++;
      begin
         logic [DATA_W-1:0] e = q_cpu.pop_front();
         n_total++; if (cpu_rdata !== e) $display("FAIL post_rd_data got=%h exp=%h", cpu_rdata, e); else n_pass++;
      end
      cpu_req = 1'b0;
      @(negedge clk_25);
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         mem[a]    = init_val(a);
         shadow[a] = init_val(a);
      end
      test_reset();
      test_cpu_write_read();
      test_vdg_only();
      test_collision();
      test_starvation();
      test_back_to_back();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
      $fatal(1);
   end

endmodule : tb_vram_arbiter
`default_nettype wire
